// File: rtl/sdp_ram_stream_rd_pkg.sv
// Shared types and helpers for the SDP RAM streaming read sequencer.
package sdp_ram_stream_rd_pkg;

    function automatic int bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } rd_state_t;

    // The FIFO must absorb every read in flight plus the word currently presented.
    localparam int FIFO_SLACK = 1;

    function automatic bit fifo_depth_ok(input int fifo_depth, input int ram_lat);
        return fifo_depth >= ram_lat + FIFO_SLACK;
    endfunction

endpackage

// File: rtl/sdp_rd_fifo.sv
// Synchronous FIFO with occupancy count; no write-to-read bypass.
module sdp_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdp_ram_stream_rd.sv
// Burst read sequencer for a simple-dual-port sync RAM, streaming words out on valid/ready.
// Optional macro SDP_RD_PERF_EN adds the perf_stall stalled-valid cycle counter.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | issuing reads while FIFO credit allows
// DRAIN  | all reads issued; waiting for the last word to be accepted
// FINISH | done pulse, back to IDLE
module sdp_ram_stream_rd
    import sdp_ram_stream_rd_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int RAM_DEPTH  = 512,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [bw(RAM_DEPTH)-1:0]  start_addr,
    input  logic [bw(RAM_DEPTH):0]    len,
    output logic                      busy,
    output logic                      done,
    output logic [bw(RAM_DEPTH)-1:0]  ram_addrb,
    output logic                      ram_enb,
    output logic                      ram_rstb,
    input  logic [DATA_W-1:0]         ram_doutb,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last
`ifdef SDP_RD_PERF_EN
    ,
    output logic [31:0]               perf_stall
`endif
);
    localparam int AW = bw(RAM_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    generate
        if (!fifo_depth_ok(FIFO_DEPTH, RAM_LAT)) begin : g_depth_chk
            $error("sdp_ram_stream_rd: FIFO_DEPTH must be at least RAM_LAT+1");
        end
    endgenerate

    rd_state_t          state_q;
    rd_state_t          state_d;
    logic [AW-1:0]      addr_q;
    logic [LW-1:0]      rem_q;
    logic [RAM_LAT-1:0] tag_v_q;
    logic [RAM_LAT-1:0] tag_l_q;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic [DATA_W:0]    fifo_rd_data;
    logic               accept;
    logic               issue;
    logic               push;
    logic               pop;

    // Credit: reads in flight plus words already buffered must leave room in the FIFO.
    assign accept    = (state_q == IDLE) && start;
    assign issue     = (state_q == ISSUE) &&
                       (($countones(tag_v_q) + int'(fifo_count)) < FIFO_DEPTH);
    assign push      = tag_v_q[RAM_LAT-1];
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign {m_last, m_data} = fifo_rd_data;
    assign ram_addrb = addr_q;
    assign ram_enb   = issue || (tag_v_q != '0);
    assign ram_rstb  = 1'b0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? FINISH : ISSUE;
            ISSUE:   if (issue && (rem_q == LW'(1))) state_d = DRAIN;
            DRAIN:   if ((tag_v_q == '0) && (fifo_count == CW'(1)) && pop && m_last)
                         state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rem_q   <= '0;
            tag_v_q <= '0;
            tag_l_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= start_addr;
                rem_q  <= len;
            end else if (issue) begin
                addr_q <= (addr_q == AW'(RAM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                rem_q  <= rem_q - LW'(1);
            end
            // Tags ride alongside the RAM pipeline so returning data is written on exit.
            tag_v_q[0] <= issue;
            tag_l_q[0] <= issue && (rem_q == LW'(1));
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_l_q[i] <= tag_l_q[i-1];
            end
        end
    end

    sdp_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({tag_l_q[RAM_LAT-1], ram_doutb}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

`ifdef SDP_RD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
        end else if (accept) begin
            perf_stall <= '0;
        end else if (m_valid && !m_ready && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sdp_ram_stream_rd.sv
// Bench for sdp_ram_stream_rd: behavioural RAM, directed and random bursts checked against a word-order model.
module tb_sdp_ram_stream_rd;
    localparam int DATA_W     = 64;
    localparam int RAM_DEPTH  = 512;
    localparam int RAM_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int AW         = 9;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     start_addr;
    logic [AW:0]       len;
    logic              busy;
    logic              done;
    logic [AW-1:0]     ram_addrb;
    logic              ram_enb;
    logic              ram_rstb;
    logic [DATA_W-1:0] ram_doutb;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
`ifdef SDP_RD_PERF_EN
    logic [31:0]       perf_stall;
`endif

    always #5 clk = ~clk;

    sdp_ram_stream_rd #(
        .DATA_W     (DATA_W),
        .RAM_DEPTH  (RAM_DEPTH),
        .RAM_LAT    (RAM_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_addrb  (ram_addrb),
        .ram_enb    (ram_enb),
        .ram_rstb   (ram_rstb),
        .ram_doutb  (ram_doutb),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef SDP_RD_PERF_EN
        ,
        .perf_stall (perf_stall)
`endif
    );

    // Behavioural RAM read port: every pipeline stage gated by the enable.
    logic [DATA_W-1:0] mem  [RAM_DEPTH];
    logic [DATA_W-1:0] pipe [RAM_LAT];

    always @(posedge clk) begin
        if (ram_enb) begin
            pipe[0] <= mem[ram_addrb];
            for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign ram_doutb = pipe[RAM_LAT-1];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string ph);
        chk({ph, "_busy"},    64'(busy),      64'd0);
        chk({ph, "_done"},    64'(done),      64'd0);
        chk({ph, "_enb"},     64'(ram_enb),   64'd0);
        chk({ph, "_addrb"},   64'(ram_addrb), 64'd0);
        chk({ph, "_m_valid"}, 64'(m_valid),   64'd0);
        chk({ph, "_m_last"},  64'(m_last),    64'd0);
        chk({ph, "_m_data"},  m_data,         64'd0);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic run_burst(input int a, input int n, input int mode, input int inject_k);
        int k, got, first_k, last_k, done_k, done_cnt, stalls, max_cnt, budget;
        bit valid_seen, enb_seen, prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic prev_last;
        got = 0; first_k = -1; last_k = -1; done_k = -1; done_cnt = 0;
        stalls = 0; max_cnt = 0; valid_seen = 0; enb_seen = 0; prev_stall = 0;
        prev_data = '0; prev_last = 0;
        budget = 6 * n + 40;

        @(negedge clk);
        start = 1; start_addr = AW'(a); len = (AW+1)'(n); m_ready = 1;
        @(negedge clk);
        start = 0;
        chk("busy_on_accept", 64'(busy), 64'd1);
        if (n > 0) chk("first_addr", 64'(ram_addrb), 64'(a));

        for (k = 0; k < budget; k++) begin
            if (k > 0) @(negedge clk);
            case (mode)
                0:       m_ready = 1;
                1:       m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: m_ready = ($urandom_range(2) != 0);
            endcase
            if (k == inject_k) begin
                start = 1; start_addr = AW'((a + 137) % RAM_DEPTH); len = (AW+1)'(5);
            end else begin
                start = 0;
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data",  m_data,       prev_data);
                chk("hold_last",  64'(m_last),  64'(prev_last));
            end
            if (m_valid && first_k < 0) first_k = k;
            if (m_valid) valid_seen = 1;
            if (ram_enb) enb_seen = 1;
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
            if (m_valid && m_ready) begin
                if (got < n) begin
                    chk("data", m_data, mem[(a + got) % RAM_DEPTH]);
                    chk("last", 64'(m_last), 64'(got == n - 1));
                end
                if (got == n - 1) last_k = k;
                got++;
            end else if (m_valid) begin
                stalls++;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (done_cnt > 0 && k >= done_k + 2) break;
        end
        start = 0;

        chk("word_count", 64'(got),      64'(n));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("idle_after", 64'(busy),     64'd0);
        chk("fifo_bound", 64'(max_cnt <= FIFO_DEPTH), 64'd1);
        if (n > 0) begin
            chk("done_after_last", 64'(done_k), 64'(last_k + 1));
        end else begin
            chk("len0_done_k",    64'(done_k),     64'd0);
            chk("len0_no_valid",  64'(valid_seen), 64'd0);
            chk("len0_no_enb",    64'(enb_seen),   64'd0);
        end
        if (mode == 0 && n > 0) begin
            chk("first_valid_lat", 64'(first_k),         64'(RAM_LAT + 1));
            chk("throughput",      64'(last_k - first_k), 64'(n - 1));
        end
`ifdef SDP_RD_PERF_EN
        chk("perf_stall", 64'(perf_stall), 64'(stalls));
`endif
    endtask

    initial begin
        rst_n = 0; start = 0; start_addr = '0; len = '0; m_ready = 0;
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        chk("ram_rstb_tied", 64'(ram_rstb), 64'd0);
`ifdef SDP_RD_PERF_EN
        chk("perf_reset", 64'(perf_stall), 64'd0);
`endif
        rst_n = 1;
        @(negedge clk);
        chk_reset_vals("post_release");

        run_burst(10, 8, 0, -1);
        run_burst(508, 6, 0, -1);
        run_burst(20, 8, 1, -1);
        run_burst(0, 0, 0, -1);
        run_burst(40, 10, 1, 3);

        // Reset after three reads have been issued.
        @(negedge clk);
        start = 1; start_addr = AW'(100); len = (AW+1)'(8); m_ready = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_valid", 64'(m_valid), 64'd0);
        end
        run_burst(200, 2, 0, -1);

        for (int r = 0; r < 6; r++) begin
            run_burst(int'($urandom_range(RAM_DEPTH - 1)), int'($urandom_range(24, 1)),
                      int'($urandom_range(2)), -1);
        end
        run_burst(300, RAM_DEPTH, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdp_ram_stream_rd.md
Name: sdp_ram_stream_rd

Overview:
Read-side sequencer that sits directly downstream of the simple-dual-port sync RAM. Takes a burst command (start address, length) and issues sequential reads on the RAM read port, tracking the fixed RAM read latency. Returned words go into a small credit-protected FIFO and leave on a valid/ready stream with a last flag. Feeds compute PEs and DMA-out stages from on-chip buffers.

Parameters:
DATA_W, 64, RAM word width; equals the RAM's NB_COL*COL_WIDTH.
RAM_DEPTH, 512, RAM entries; address width is bw(RAM_DEPTH).
RAM_LAT, 2, RAM read latency in cycles: 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
FIFO_DEPTH, 4, output FIFO entries; must be >= RAM_LAT+1; elaboration error otherwise.

Ports:
clk  in  1  single clock; same clock as the RAM.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle command strobe; sampled only when busy=0.
start_addr  in  bw(RAM_DEPTH)  first read address.
len  in  bw(RAM_DEPTH)+1  words to read, 0..RAM_DEPTH.
busy  out  1  command accepted and not yet done.
done  out  1  one-cycle pulse when the last word is accepted downstream.
ram_addrb  out  bw(RAM_DEPTH)  RAM read address.
ram_enb  out  1  RAM read enable.
ram_rstb  out  1  RAM output reset; tied 0.
ram_doutb  in  DATA_W  RAM read data.
m_valid  out  1  output word valid.
m_ready  in  1  downstream ready.
m_data  out  DATA_W  output word.
m_last  out  1  marks the final word of the burst.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, ram_enb=0, ram_addrb=0, m_valid=0, m_last=0, m_data=0. FIFO is emptied, in-flight tracking is cleared, FSM goes to IDLE.
- Reset mid-burst aborts the burst. Data returning from the RAM afterwards is discarded.
- FSM states:
  - IDLE -> ISSUE on start with len>0.
  - IDLE -> FINISH on start with len==0: done pulses the next cycle, no output words.
  - ISSUE -> DRAIN once len reads are issued.
  - DRAIN -> FINISH when the in-flight count is 0, the FIFO is empty and the last handshake has occurred.
  - FINISH -> IDLE unconditionally; done=1 for that single cycle.
  - busy=1 in ISSUE, DRAIN and FINISH.
- start while busy=1 is ignored. Input fields are captured on the accepted start cycle.
- Issue rule: a read issues in cycle t iff state==ISSUE and (inflight + fifo_count) < FIFO_DEPTH. This credit check guarantees the FIFO never overflows.
- Read enable: ram_enb=1 whenever a read issues or any read is in flight. The RAM enable gates every RAM pipeline stage, so it must stay high until data emerges.
- Latency tracking: a RAM_LAT-deep valid shift register tags issued reads. A tag exiting it writes ram_doutb into the FIFO the same cycle.
- Addressing: ram_addrb increments per issued read and wraps from RAM_DEPTH-1 to 0. Wrap is an explicit compare, so non-power-of-2 depths work.
- Data latency: first m_valid appears RAM_LAT+1 cycles after start when m_ready is held high.
- Throughput: 1 word/cycle sustained with m_ready=1.
- Stream protocol: m_data and m_last hold stable while m_valid=1 and m_ready=0. m_last=1 only on word index len-1.
- FIFO simultaneous read/write: legal when full or empty. An empty FIFO is not bypassed; data is registered first.

Optional Feature:
SDP_RD_PERF_EN.
- Defined: adds output perf_stall  out  32. Counts cycles with m_valid=1 and m_ready=0, saturating at 2^32-1. Clears on accepted start and on reset.
- Undefined: port and counter are absent.

Decomposition:
- GLOBAL_PARAM package: bw() (existing); typedef for the FSM state enum (IDLE, ISSUE, DRAIN, FINISH); assertion helper constant for FIFO_DEPTH>=RAM_LAT+1.
- One sub-module: sdp_rd_fifo, a parameterised synchronous FIFO with count output, no bypass, async active-low reset.

Test Plan:
- start_addr=10, len=8, m_ready=1, RAM_LAT=2: addrb 10..17; m_data = mem[10..17] on consecutive cycles; first valid at cycle 3; m_last on the 8th word; done one cycle later.
- start_addr=508, len=6, RAM_DEPTH=512: addresses 508,509,510,511,0,1; data order correct.
- len=8 with m_ready toggling 1,0,0,1 repeating: no word lost or duplicated; FIFO count never exceeds 4; with the perf macro, perf_stall equals the count of stalled-valid cycles.
- len=0: done pulses once, m_valid never asserts, ram_enb stays 0.
- start pulse mid-burst with different addr/len: ignored; original burst completes unchanged.
- rst_n asserted after 3 reads issued: all outputs go to reset values immediately; a new start with len=2 returns exactly 2 correct words with no stale data.
